// File: rtl/timing_check_pkg.sv
// timing_check_pkg: shared types and helpers for the timing check monitor.
//   viol_kind_e   - violation kinds, also the bit indices of viol_sticky
//   hold_state_e  - hold window FSM states
//   width_state_e - high-phase width FSM states
//   sat_inc       - saturating add of a small step to a counter value
package timing_check_pkg;
  typedef enum logic [1:0] {V_SETUP = 2'd0, V_HOLD = 2'd1, V_WIDTH = 2'd2} viol_kind_e;
  typedef enum logic {H_IDLE, H_WIN} hold_state_e;
  typedef enum logic {W_LOW, W_HIGH} width_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] step, input logic [31:0] max);
    return (v + step > max) ? max : v + step;
  endfunction
endpackage

// File: rtl/tc_edge_sampler.sv
// tc_edge_sampler: two-flop synchronizer plus history flop with edge detect.
//   clk  - sampling clock
//   rst  - asynchronous active-low reset
//   pin  - asynchronous input pin
//   lvl  - synchronized level (s2)
//   rise - s2 rose relative to s3
//   fall - s2 fell relative to s3
//   any  - s2 differs from s3
module tc_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall,
  output logic any
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {pin, s1, s2};
  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign any  = s2 ^ s3;
endmodule

// File: rtl/timing_check_monitor.sv
// timing_check_monitor: setup, hold and min-pulse-width checker sampled on clk.
//   clk, rst          - sampling clock, asynchronous active-low reset
//   mon_clk, mon_d    - monitored clock and data pins
//   cond              - check enable, sampled alongside the pins
//   clr               - synchronous clear of viol_sticky and viol_count
//   setup_viol, hold_viol, width_viol - one-cycle violation pulses
//   notifier          - toggles once per cycle with any violation
//   viol_sticky       - sticky {width, hold, setup} flags
//   viol_count        - saturating total of violations
module timing_check_monitor
  import timing_check_pkg::*;
#(
  parameter int unsigned SETUP_TICKS = 4,
  parameter int unsigned HOLD_TICKS  = 2,
  parameter int unsigned MIN_WIDTH   = 10,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mon_clk,
  input  logic          mon_d,
  input  logic          cond,
  input  logic          clr,
  output logic          setup_viol,
  output logic          hold_viol,
  output logic          width_viol,
  output logic          notifier,
  output logic [2:0]    viol_sticky,
  output logic [CW-1:0] viol_count
);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_TICKS);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_TICKS);
  logic mc_lvl, mc_rise, mc_fall, mc_any;
  logic d_lvl, d_rise, d_fall, d_any;
  logic c_lvl, c_rise, c_fall, c_any;
  logic unused_edges;
  tc_edge_sampler u_clk (.clk(clk), .rst(rst), .pin(mon_clk), .lvl(mc_lvl), .rise(mc_rise), .fall(mc_fall), .any(mc_any));
  tc_edge_sampler u_d   (.clk(clk), .rst(rst), .pin(mon_d),   .lvl(d_lvl),  .rise(d_rise),  .fall(d_fall),  .any(d_any));
  tc_edge_sampler u_c   (.clk(clk), .rst(rst), .pin(cond),    .lvl(c_lvl),  .rise(c_rise),  .fall(c_fall),  .any(c_any));
  assign unused_edges = ^{mc_lvl, mc_any, d_lvl, d_rise, d_fall, c_rise, c_fall, c_any};
  logic [CW-1:0] since_d, hold_cnt, hold_cnt_nx, hi_cnt, hi_cnt_nx;
  hold_state_e   hold_st, hold_nx;
  width_state_e  width_st, width_nx;
  logic          check_clk, setup_hit, hold_hit, width_hit;
  logic [2:0]    hits;
  assign check_clk = mc_rise & c_lvl;
  // A data edge on the clock edge itself reads as since_d == 0.
  assign setup_hit = check_clk & (d_any | (since_d < SETUP_L));
  // A qualifying posedge (re)opens the window and takes priority over a
  // coincident data edge, which is a setup matter only.
  always_comb begin
    hold_nx = hold_st;
    hold_cnt_nx = hold_cnt;
    hold_hit = 1'b0;
    if (check_clk) begin
      hold_nx = H_WIN;
      hold_cnt_nx = '0;
    end else if (hold_st == H_WIN) begin
      hold_cnt_nx = hold_cnt + 1'b1;
      if (d_any && hold_cnt < HOLD_L) begin
        hold_hit = 1'b1;
        hold_nx = H_IDLE;
      end else if (hold_cnt_nx >= HOLD_L) hold_nx = H_IDLE;
    end
  end
  // hi_cnt + 1 equals the number of sampled cycles with s3 high.
  always_comb begin
    width_nx = width_st;
    hi_cnt_nx = hi_cnt;
    width_hit = 1'b0;
    if (width_st == W_LOW) begin
      if (mc_rise) begin
        width_nx = W_HIGH;
        hi_cnt_nx = '0;
      end
    end else if (mc_fall) begin
      width_nx = W_LOW;
      width_hit = c_lvl && (32'(hi_cnt) + 32'd1 < MIN_WIDTH);
    end else hi_cnt_nx = CW'(sat_inc(32'(hi_cnt), 32'd1, 32'(CNT_MAX)));
  end
  always_comb begin
    hits = '0;
    hits[V_SETUP] = setup_hit;
    hits[V_HOLD]  = hold_hit;
    hits[V_WIDTH] = width_hit;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      since_d <= '1;
      hold_st <= H_IDLE;
      hold_cnt <= '0;
      width_st <= W_LOW;
      hi_cnt <= '0;
      setup_viol <= 1'b0;
      hold_viol <= 1'b0;
      width_viol <= 1'b0;
      notifier <= 1'b0;
      viol_sticky <= '0;
      viol_count <= '0;
    end else begin
      since_d <= d_any ? '0 : CW'(sat_inc(32'(since_d), 32'd1, 32'(CNT_MAX)));
      hold_st <= hold_nx;
      hold_cnt <= hold_cnt_nx;
      width_st <= width_nx;
      hi_cnt <= hi_cnt_nx;
      setup_viol <= hits[V_SETUP];
      hold_viol <= hits[V_HOLD];
      width_viol <= hits[V_WIDTH];
      notifier <= notifier ^ (|hits);
      viol_sticky <= clr ? '0 : viol_sticky | hits;
      viol_count <= clr ? '0 : CW'(sat_inc(32'(viol_count), 32'($countones(hits)), 32'(CNT_MAX)));
    end
endmodule

// File: tb/tb_timing_check_monitor.sv
// tb_timing_check_monitor: directed self-checking bench for timing_check_monitor.
module tb_timing_check_monitor;
  logic clk = 1'b0, rst = 1'b0, mon_clk = 1'b0, mon_d = 1'b0, cond = 1'b0, clr = 1'b0;
  logic setup_viol, hold_viol, width_viol, notifier;
  logic [2:0] viol_sticky;
  logic [7:0] viol_count;
  int vectors = 0, miscompares = 0;
  int su_n = 0, ho_n = 0, wi_n = 0;
  timing_check_monitor dut (
    .clk(clk), .rst(rst), .mon_clk(mon_clk), .mon_d(mon_d), .cond(cond), .clr(clr),
    .setup_viol(setup_viol), .hold_viol(hold_viol), .width_viol(width_viol),
    .notifier(notifier), .viol_sticky(viol_sticky), .viol_count(viol_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    su_n <= su_n + int'(setup_viol);
    ho_n <= ho_n + int'(hold_viol);
    wi_n <= wi_n + int'(width_viol);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick(3);
    vectors++;
    if ({setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count} !== 14'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0", {setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count});
    end
    rst = 1'b1;
    cond = 1'b1;
    tick(20);
    vectors++;
    if ({setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count} !== 14'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got %b want 0", {setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count});
    end
  endtask
  task automatic test_setup;
    mon_d = 1'b1;
    tick(2);
    mon_clk = 1'b1;
    tick(3);
    vectors++;
    if ({setup_viol, hold_viol} !== 2'b10) begin
      miscompares++;
      $display("FAIL setup_pulse: got %b want 10", {setup_viol, hold_viol});
    end
    tick(1);
    vectors++;
    if ({setup_viol, notifier, viol_sticky, viol_count} !== {1'b0, 1'b1, 3'b001, 8'd1}) begin
      miscompares++;
      $display("FAIL setup_state: got pulse=%b notifier=%b sticky=%b count=%0d want 0 1 001 1", setup_viol, notifier, viol_sticky, viol_count);
    end
    tick(8);
    mon_clk = 1'b0;
    tick(10);
  endtask
  task automatic test_hold;
    mon_d = 1'b0;
    tick(5);
    mon_clk = 1'b1;
    tick(1);
    mon_d = 1'b1;
    tick(3);
    vectors++;
    if ({setup_viol, hold_viol} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_pulse: got %b want 01", {setup_viol, hold_viol});
    end
    tick(1);
    vectors++;
    if ({notifier, viol_sticky, viol_count} !== {1'b0, 3'b011, 8'd2}) begin
      miscompares++;
      $display("FAIL hold_state: got notifier=%b sticky=%b count=%0d want 0 011 2", notifier, viol_sticky, viol_count);
    end
    tick(7);
    mon_clk = 1'b0;
    tick(10);
  endtask
  task automatic test_hold_boundary;
    mon_d = 1'b0;
    tick(10);
    mon_clk = 1'b1;
    tick(3);
    mon_d = 1'b1;
    tick(9);
    mon_clk = 1'b0;
    tick(10);
    vectors++;
    if (ho_n !== 1) begin
      miscompares++;
      $display("FAIL hold_outside_window: got %0d hold pulses want 1", ho_n);
    end
    mon_clk = 1'b1;
    tick(2);
    mon_d = 1'b0;
    tick(3);
    vectors++;
    if (hold_viol !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_last_tick: got %b want 1", hold_viol);
    end
    tick(7);
    mon_clk = 1'b0;
    tick(10);
    vectors++;
    if ({su_n, ho_n, int'(notifier), int'(viol_count)} !== {32'd1, 32'd2, 32'd1, 32'd3}) begin
      miscompares++;
      $display("FAIL hold_totals: got setup=%0d hold=%0d notifier=%b count=%0d want 1 2 1 3", su_n, ho_n, notifier, viol_count);
    end
  endtask
  task automatic test_width;
    mon_clk = 1'b1;
    tick(6);
    mon_clk = 1'b0;
    tick(3);
    vectors++;
    if (width_viol !== 1'b1) begin
      miscompares++;
      $display("FAIL width_6: got %b want 1", width_viol);
    end
    tick(1);
    vectors++;
    if ({notifier, viol_sticky, viol_count} !== {1'b0, 3'b111, 8'd4}) begin
      miscompares++;
      $display("FAIL width_state: got notifier=%b sticky=%b count=%0d want 0 111 4", notifier, viol_sticky, viol_count);
    end
    tick(10);
    mon_clk = 1'b1;
    tick(12);
    mon_clk = 1'b0;
    tick(3);
    vectors++;
    if (width_viol !== 1'b0 || wi_n !== 1) begin
      miscompares++;
      $display("FAIL width_12: got pulse=%b total=%0d want 0 1", width_viol, wi_n);
    end
    tick(10);
    mon_clk = 1'b1;
    tick(9);
    mon_clk = 1'b0;
    tick(3);
    vectors++;
    if (width_viol !== 1'b1) begin
      miscompares++;
      $display("FAIL width_9: got %b want 1", width_viol);
    end
    tick(10);
    mon_clk = 1'b1;
    tick(10);
    mon_clk = 1'b0;
    tick(10);
    vectors++;
    if ({wi_n, int'(notifier), int'(viol_count)} !== {32'd2, 32'd1, 32'd5}) begin
      miscompares++;
      $display("FAIL width_10: got total=%0d notifier=%b count=%0d want 2 1 5", wi_n, notifier, viol_count);
    end
  endtask
  task automatic test_coincident;
    mon_d = ~mon_d;
    mon_clk = 1'b1;
    tick(3);
    vectors++;
    if ({setup_viol, hold_viol} !== 2'b10) begin
      miscompares++;
      $display("FAIL coincident_pulse: got %b want 10", {setup_viol, hold_viol});
    end
    tick(9);
    mon_clk = 1'b0;
    tick(10);
    vectors++;
    if ({su_n, ho_n, int'(notifier), int'(viol_count)} !== {32'd2, 32'd2, 32'd0, 32'd6}) begin
      miscompares++;
      $display("FAIL coincident_totals: got setup=%0d hold=%0d notifier=%b count=%0d want 2 2 0 6", su_n, ho_n, notifier, viol_count);
    end
    cond = 1'b0;
    tick(10);
    mon_d = ~mon_d;
    mon_clk = 1'b1;
    tick(5);
    mon_clk = 1'b0;
    tick(10);
    vectors++;
    if ({su_n, ho_n, wi_n, int'(notifier), int'(viol_count)} !== {32'd2, 32'd2, 32'd2, 32'd0, 32'd6}) begin
      miscompares++;
      $display("FAIL cond_off: got setup=%0d hold=%0d width=%0d notifier=%b count=%0d want 2 2 2 0 6", su_n, ho_n, wi_n, notifier, viol_count);
    end
    cond = 1'b1;
    tick(10);
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 249; i++) begin
      mon_clk = 1'b1;
      tick(1);
      mon_clk = 1'b0;
      tick(1);
    end
    tick(4);
    vectors++;
    if ({int'(viol_count), int'(notifier)} !== {32'd255, 32'd1}) begin
      miscompares++;
      $display("FAIL count_reach_max: got count=%0d notifier=%b want 255 1", viol_count, notifier);
    end
    for (int i = 0; i < 10; i++) begin
      mon_clk = 1'b1;
      tick(1);
      mon_clk = 1'b0;
      tick(1);
    end
    tick(4);
    vectors++;
    if ({int'(viol_count), int'(notifier), wi_n} !== {32'd255, 32'd1, 32'd261}) begin
      miscompares++;
      $display("FAIL count_saturate: got count=%0d notifier=%b width=%0d want 255 1 261", viol_count, notifier, wi_n);
    end
  endtask
  task automatic test_clr;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if ({notifier, viol_sticky, viol_count} !== {1'b1, 3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL clr: got notifier=%b sticky=%b count=%0d want 1 000 0", notifier, viol_sticky, viol_count);
    end
    tick(10);
    mon_clk = 1'b1;
    tick(1);
    mon_clk = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if ({width_viol, notifier, viol_sticky, viol_count} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL clr_coincident: got pulse=%b notifier=%b sticky=%b count=%0d want 1 0 000 0", width_viol, notifier, viol_sticky, viol_count);
    end
    tick(5);
    vectors++;
    if ({viol_sticky, viol_count} !== 11'b0) begin
      miscompares++;
      $display("FAIL clr_lost: got sticky=%b count=%0d want 000 0", viol_sticky, viol_count);
    end
  endtask
  task automatic test_reset_mid_window;
    int s0, h0, w0;
    tick(10);
    mon_clk = 1'b1;
    tick(3);
    rst = 1'b0;
    s0 = su_n;
    h0 = ho_n;
    w0 = wi_n;
    tick(1);
    mon_d = ~mon_d;
    mon_clk = 1'b0;
    tick(2);
    vectors++;
    if ({setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count} !== 14'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %b want 0", {setup_viol, hold_viol, width_viol, notifier, viol_sticky, viol_count});
    end
    rst = 1'b1;
    tick(10);
    vectors++;
    if ({su_n - s0, ho_n - h0, wi_n - w0} !== 96'b0 || {notifier, viol_sticky, viol_count} !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release: got pulses %0d/%0d/%0d notifier=%b sticky=%b count=%0d want 0", su_n - s0, ho_n - h0, wi_n - w0, notifier, viol_sticky, viol_count);
    end
  endtask
  initial begin
    test_reset;
    test_setup;
    test_hold;
    test_hold_boundary;
    test_width;
    test_coincident;
    test_saturation;
    test_clr;
    test_reset_mid_window;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timing_check_monitor.md
Name: timing_check_monitor

Overview:
- Synthesizable checker for the timing relations a specify block declares: setup, hold and minimum pulse width of a monitored data/clock pair.
- Samples both signals on a fast clock `clk`, measures intervals in clk ticks, flags violations and toggles a notifier register.
- Sits downstream of the cell under check: consumes its clock/data pins and produces the notifier that the checked cell's model consumes.

Parameters:
- SETUP_TICKS, 4, minimum ticks from last data change to monitored-clock posedge.
- HOLD_TICKS, 2, ticks after a monitored-clock posedge during which data must stay stable.
- MIN_WIDTH, 10, minimum high-phase length of the monitored clock, in ticks.
- CW, 8, width of interval and violation counters; must hold max(SETUP_TICKS, HOLD_TICKS, MIN_WIDTH) + 1.

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous, active-low reset.
- mon_clk  in  1  monitored clock pin.
- mon_d  in  1  monitored data pin.
- cond  in  1  check enable (the &&& condition), sampled with the pins.
- clr  in  1  synchronous clear of counters and sticky flags.
- setup_viol  out  1  one-cycle pulse on setup violation.
- hold_viol  out  1  one-cycle pulse on hold violation.
- width_viol  out  1  one-cycle pulse on width violation.
- notifier  out  1  toggles once per cycle in which any violation pulses.
- viol_sticky  out  3  sticky {width, hold, setup} flags.
- viol_count  out  CW  total violations, saturating at all-ones.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0; notifier 0.
  - sampler stages 0; hold FSM IDLE; width FSM LOW.
  - since_d preset to all-ones, so there is no spurious setup violation after reset.
- Sampling:
  - mon_clk, mon_d and cond pass through two sync flops (s1, s2) plus a history flop s3.
  - An edge is detected in the cycle where s2 != s3.
  - Violation outputs are registered, one cycle after edge detection.
  - Pin change to pulse = 3 clk cycles.
- since_d counter:
  - cleared to 0 on a data edge; otherwise increments, saturating at all-ones.
- Setup:
  - on a mon_clk posedge with cond_s=1, violation if since_d < SETUP_TICKS.
  - since_d here is the value before any same-cycle clear.
  - A data edge in the same cycle as the clk posedge counts as since_d=0, i.e. a setup violation.
- Hold FSM, IDLE/HOLD_WIN:
  - mon_clk posedge with cond_s=1 → HOLD_WIN, hold_cnt=0.
  - In HOLD_WIN, hold_cnt increments each cycle.
  - A data edge while hold_cnt < HOLD_TICKS → hold_viol, return to IDLE.
  - hold_cnt reaching HOLD_TICKS → IDLE.
  - A data edge coincident with the posedge that opens the window is not a hold violation (setup only).
  - A new posedge in HOLD_WIN restarts the window.
- Width FSM, LOW/HIGH:
  - mon_clk posedge → HIGH, hi_cnt=0; hi_cnt increments each cycle in HIGH, saturating.
  - On negedge → LOW; width_viol if cond_s=1 and hi_cnt+1 < MIN_WIDTH.
  - The high phase is measured as sampled cycles where s3=1.
- Pulses, notifier and counters:
  - Multiple violations in one cycle assert each pulse.
  - notifier toggles once per cycle regardless of how many violations occur.
  - viol_count adds the number of simultaneous violations (1..3), saturating.
- clr:
  - zeroes viol_sticky and viol_count next cycle; does not touch notifier, FSMs or since_d.
  - A violation in the same cycle as clr is lost from count and sticky, but still pulses and toggles notifier.
- cond_s=0: no setup or width checks on that edge, and no hold window opens; an already-open window continues.
- Reset asserted mid-window: FSMs return to their reset states immediately; no pulse after release.

Decomposition:
- Shared package `timing_check_pkg`:
  - violation-kind enum, used as the viol_sticky bit indices;
  - hold FSM state enum;
  - width FSM state enum;
  - saturating-increment function.
- One sub-module `tc_edge_sampler`: 2-flop sync, history flop, rise/fall/any-edge outputs. Instantiated once per input (mon_clk, mon_d, cond).

Test Plan:
- d toggles 2 ticks before mon_clk rise, cond=1 → setup_viol pulse 3 cycles after the rise; notifier 0→1; viol_count=1; viol_sticky=3'b001.
- d toggles 5 ticks before rise → no pulse; then d toggles 1 tick after rise → hold_viol; notifier 1→0; viol_count=2; viol_sticky=3'b011.
- mon_clk high 6 ticks → width_viol at fall + 3 cycles; high 12 ticks → none.
- d and mon_clk rise on the same tick → setup_viol only, no hold_viol; cond=0 for the same stimulus → no pulses, notifier unchanged.
- Force 256 violations with CW=8 → viol_count holds 255; clr → count 0 and sticky 0, notifier unchanged.
- Assert rst 1 tick into a hold window, d toggles during reset, release → all outputs 0 and no pulse over the next 10 cycles.
